// File: rtl/vdp_cpu_port.sv
// CPU-side TMS9918-style port for the MSX VDP.
// Decodes data-port (port_sel=0) and control/status-port (port_sel=1) accesses
// into VRAM port-A reads/writes and setup registers R0-R7. It also drives the
// video generator's mode/table/colour inputs, returns status and generates n_int.
//
// Ports
//   clk, n_reset            cpu clock, async active-low reset
//   port_sel, cpu_wr/rd     CPU access decode (single-cycle strobes)
//   cpu_din / cpu_dout      CPU write data / registered read data
//   vram_addr/dout/wr/rd    VRAM port-A request side
//   vram_din                VRAM read data, valid READ_LAT cycles after vram_rd
//   vblank, coll_in,        video-domain status, synchronised here
//   sprite5_in
//   mode .. back_color      decoded setup-register fields
//   n_int                   active-low frame interrupt
//
// Prefetch FSM
//   state      | meaning
//   ST_IDLE    | no VRAM read in flight, CPU accesses accepted
//   ST_ISSUE   | vram_rd pulse at current address
//   ST_WAIT    | down-count READ_LAT cycles of VRAM latency
//   ST_CAPTURE | load read buffer from vram_din, bump address
module vdp_cpu_port #(
   parameter int READ_LAT    = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        port_sel,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic [13:0] vram_addr,
   output logic [7:0]  vram_dout,
   output logic        vram_wr,
   output logic        vram_rd,
   input  logic [7:0]  vram_din,
   input  logic        vblank,
   input  logic        coll_in,
   input  logic [4:0]  sprite5_in,
   output logic [1:0]  mode,
   output logic        video_on,
   output logic        sprite_large,
   output logic        sprite_enlarged,
   output logic        vert_retrace_int,
   output logic [13:0] name_table_addr,
   output logic [13:0] color_table_addr,
   output logic [13:0] font_addr,
   output logic [13:0] sprite_attr_addr,
   output logic [13:0] sprite_pattern_table_addr,
   output logic [3:0]  text_color,
   output logic [3:0]  back_color,
   output logic        n_int
);

   localparam int WCW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_CAPTURE = 2'd3
   } pf_state_t;

   pf_state_t state_q, state_d;

   logic [7:0]     regs_q [8];
   logic [13:0]    addr_q;
   logic           flag_q;
   logic [7:0]     b1_q;
   logic [7:0]     rbuf_q;
   logic           reg_pend_q;
   logic [2:0]     reg_idx_q;
   logic [7:0]     cpu_dout_q;
   logic           vram_wr_q;
   logic [13:0]    wr_addr_q;
   logic [7:0]     wr_data_q;
   logic           f_q;
   logic           c_q;
   logic           n_int_q;
   logic [WCW-1:0] wait_cnt_q;

   logic [SYNC_STAGES-1:0]      vb_sync_q;
   logic [SYNC_STAGES-1:0]      col_sync_q;
   logic [SYNC_STAGES-1:0][4:0] s5_sync_q;
   logic                        vb_prev_q;

   logic       idle;
   logic       ctrl_wr, data_wr, data_rd, stat_rd;
   logic       start_pf;
   logic       vb_s, col_s, vb_rise;
   logic [4:0] s5_s;

   // CPU accesses are only honoured while no prefetch is in flight
   assign idle    = (state_q == ST_IDLE);
   assign ctrl_wr = cpu_wr &  port_sel & idle;
   assign data_wr = cpu_wr & ~port_sel & idle;
   assign data_rd = cpu_rd & ~port_sel & idle;
   assign stat_rd = cpu_rd &  port_sel & idle;

   // Second control byte with bit7=0, bit6=0 is a read-address setup
   assign start_pf = (ctrl_wr & flag_q & ~cpu_din[7] & ~cpu_din[6]) | data_rd;

   assign vb_s    = vb_sync_q[SYNC_STAGES-1];
   assign col_s   = col_sync_q[SYNC_STAGES-1];
   assign s5_s    = s5_sync_q[SYNC_STAGES-1];
   assign vb_rise = vb_s & ~vb_prev_q;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         vb_sync_q  <= '0;
         col_sync_q <= '0;
         s5_sync_q  <= '0;
         vb_prev_q  <= 1'b0;
      end else begin
         vb_sync_q  <= {vb_sync_q[SYNC_STAGES-2:0], vblank};
         col_sync_q <= {col_sync_q[SYNC_STAGES-2:0], coll_in};
         s5_sync_q  <= {s5_sync_q[SYNC_STAGES-2:0], sprite5_in};
         vb_prev_q  <= vb_s;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_ISSUE)
            wait_cnt_q <= WCW'(READ_LAT - 1);
         else if (state_q == ST_WAIT && wait_cnt_q != '0)
            wait_cnt_q <= wait_cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      vram_rd = 1'b0;
      case (state_q)
         ST_IDLE:    if (start_pf) state_d = ST_ISSUE;
         ST_ISSUE: begin
            vram_rd = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT:    if (wait_cnt_q == '0) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
         addr_q     <= '0;
         flag_q     <= 1'b0;
         b1_q       <= '0;
         rbuf_q     <= '0;
         reg_pend_q <= 1'b0;
         reg_idx_q  <= '0;
         cpu_dout_q <= '0;
         vram_wr_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         f_q        <= 1'b0;
         c_q        <= 1'b0;
         n_int_q    <= 1'b1;
      end else begin
         // Register write lands one cycle after the second control byte
         reg_pend_q <= ctrl_wr & flag_q & cpu_din[7];
         if (ctrl_wr & flag_q & cpu_din[7])
            reg_idx_q <= cpu_din[2:0];
         if (reg_pend_q)
            regs_q[reg_idx_q] <= b1_q;

         if (ctrl_wr)
            flag_q <= ~flag_q;
         else if (data_wr | data_rd | stat_rd)
            flag_q <= 1'b0;

         if (ctrl_wr & ~flag_q)
            b1_q <= cpu_din;

         // Address sources are exclusive: CPU ops only in IDLE, capture only outside it
         if (ctrl_wr & flag_q & ~cpu_din[7])
            addr_q <= {cpu_din[5:0], b1_q};
         else if (data_wr || state_q == ST_CAPTURE)
            addr_q <= addr_q + 14'd1;

         if (data_wr)
            rbuf_q <= cpu_din;
         else if (state_q == ST_CAPTURE)
            rbuf_q <= vram_din;

         vram_wr_q <= data_wr;
         if (data_wr) begin
            wr_addr_q <= addr_q;
            wr_data_q <= cpu_din;
         end

         if (stat_rd)
            cpu_dout_q <= {f_q, 1'b0, c_q, s5_s};
         else if (data_rd)
            cpu_dout_q <= rbuf_q;

         // A status read clears the flags, but a coincident set event wins
         if (vb_rise)
            f_q <= 1'b1;
         else if (stat_rd)
            f_q <= 1'b0;

         if (col_s)
            c_q <= 1'b1;
         else if (stat_rd)
            c_q <= 1'b0;

         n_int_q <= ~(f_q & regs_q[1][5]);
      end
   end

   assign cpu_dout  = cpu_dout_q;
   assign vram_wr   = vram_wr_q;
   assign vram_dout = wr_data_q;
   assign vram_addr = vram_wr_q ? wr_addr_q : addr_q;
   assign n_int     = n_int_q;

   always_comb begin
      mode = 2'd1;
      if (regs_q[1][4])
         mode = 2'd0;
      else if (regs_q[0][1])
         mode = 2'd2;
      else if (regs_q[1][3])
         mode = 2'd3;
   end

   assign video_on                  = regs_q[1][6];
   assign vert_retrace_int          = regs_q[1][5];
   assign sprite_large              = regs_q[1][1];
   assign sprite_enlarged           = regs_q[1][0];
   assign name_table_addr           = {regs_q[2][3:0], 10'b0};
   assign color_table_addr          = {regs_q[3], 6'b0};
   assign font_addr                 = {regs_q[4][2:0], 11'b0};
   assign sprite_attr_addr          = {regs_q[5][6:0], 7'b0};
   assign sprite_pattern_table_addr = {regs_q[6][2:0], 11'b0};
   assign text_color                = regs_q[7][7:4];
   assign back_color                = regs_q[7][3:0];

   // Register bits with no function in this VDP subset
   logic unused_reg_bits;
   assign unused_reg_bits = ^{regs_q[0][7:2], regs_q[0][0], regs_q[1][7], regs_q[1][2],
                              regs_q[2][7:4], regs_q[4][7:3], regs_q[5][7], regs_q[6][7:3]};

endmodule

// File: tb/tb_vdp_cpu_port.sv
module tb_vdp_cpu_port;

   localparam int READ_LAT    = 1;
   localparam int SYNC_STAGES = 2;
   localparam int GAP         = 6;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        port_sel, cpu_wr, cpu_rd;
   logic [7:0]  cpu_din, cpu_dout;
   logic [13:0] vram_addr;
   logic [7:0]  vram_dout, vram_din;
   logic        vram_wr, vram_rd;
   logic        vblank, coll_in;
   logic [4:0]  sprite5_in;
   logic [1:0]  mode;
   logic        video_on, sprite_large, sprite_enlarged, vert_retrace_int;
   logic [13:0] name_table_addr, color_table_addr, font_addr, sprite_attr_addr;
   logic [13:0] sprite_pattern_table_addr;
   logic [3:0]  text_color, back_color;
   logic        n_int;

   vdp_cpu_port #(.READ_LAT(READ_LAT), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .n_reset(n_reset), .port_sel(port_sel), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_addr(vram_addr), .vram_dout(vram_dout),
      .vram_wr(vram_wr), .vram_rd(vram_rd), .vram_din(vram_din), .vblank(vblank),
      .coll_in(coll_in), .sprite5_in(sprite5_in), .mode(mode), .video_on(video_on),
      .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
      .vert_retrace_int(vert_retrace_int), .name_table_addr(name_table_addr),
      .color_table_addr(color_table_addr), .font_addr(font_addr),
      .sprite_attr_addr(sprite_attr_addr),
      .sprite_pattern_table_addr(sprite_pattern_table_addr),
      .text_color(text_color), .back_color(back_color), .n_int(n_int)
   );

   always #5 clk = ~clk;

   // VRAM environment: registered read data, one-cycle latency
   logic [7:0]  vmem [16384];
   logic [7:0]  vdin = 8'h00;
   logic        pre_en = 1'b0;
   logic [13:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;
   assign vram_din = vdin;

   always @(posedge clk) begin
      if (vram_wr) vmem[vram_addr] <= vram_dout;
      if (vram_rd) vdin <= vmem[vram_addr];
      if (pre_en)  vmem[pre_addr] <= pre_data;
   end

   // Behavioural model of the programmer-visible state
   logic [7:0]  m_reg [8];
   logic [7:0]  m_mem [16384];
   logic [13:0] m_addr;
   logic        m_flag;
   logic [7:0]  m_b1;
   logic [7:0]  m_buf;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic busy    = 1'b1;
   logic nint_after;
   logic [7:0] got;
   int   cnt;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      m_addr = '0; m_flag = 1'b0; m_b1 = '0; m_buf = '0;
   endtask

   function automatic logic [1:0] exp_mode();
      if (m_reg[1][4])      return 2'd0;
      else if (m_reg[0][1]) return 2'd2;
      else if (m_reg[1][3]) return 2'd3;
      return 2'd1;
   endfunction

   always @(negedge clk) begin
      if (n_reset && !busy) begin
         check("mode",        {30'd0, mode},            {30'd0, exp_mode()});
         check("video_on",    {31'd0, video_on},        {31'd0, m_reg[1][6]});
         check("vri",         {31'd0, vert_retrace_int},{31'd0, m_reg[1][5]});
         check("spr_large",   {31'd0, sprite_large},    {31'd0, m_reg[1][1]});
         check("spr_enl",     {31'd0, sprite_enlarged}, {31'd0, m_reg[1][0]});
         check("name_tab",    {18'd0, name_table_addr}, 32'(m_reg[2] % 16) * 1024);
         check("color_tab",   {18'd0, color_table_addr},32'(m_reg[3]) * 64);
         check("font_tab",    {18'd0, font_addr},       32'(m_reg[4] % 8) * 2048);
         check("sattr_tab",   {18'd0, sprite_attr_addr},32'(m_reg[5] % 128) * 128);
         check("spat_tab",    {18'd0, sprite_pattern_table_addr}, 32'(m_reg[6] % 8) * 2048);
         check("text_color",  {28'd0, text_color},      32'(m_reg[7] / 16));
         check("back_color",  {28'd0, back_color},      32'(m_reg[7] % 16));
         check("idle_wr",     {31'd0, vram_wr},         32'd0);
         check("idle_rd",     {31'd0, vram_rd},         32'd0);
      end
   end

   task automatic bus_op(input logic sel, input logic wr, input logic [7:0] d);
      @(negedge clk);
      port_sel = sel; cpu_wr = wr; cpu_rd = ~wr; cpu_din = d;
      @(posedge clk); #1;
      cpu_wr = 1'b0; cpu_rd = 1'b0;
   endtask

   task automatic idle_gap();
      repeat (GAP) @(posedge clk);
      #1 busy = 1'b0;
   endtask

   task automatic ctrl_wr(input logic [7:0] b);
      logic pf; logic [13:0] pfa;
      busy = 1'b1; pf = 1'b0; pfa = '0;
      bus_op(1'b1, 1'b1, b);
      if (!m_flag) begin
         m_b1 = b; m_flag = 1'b1;
      end else begin
         m_flag = 1'b0;
         if (b[7]) m_reg[b[2:0]] = m_b1;
         else begin
            m_addr = {b[5:0], m_b1};
            if (!b[6]) begin
               pf = 1'b1; pfa = m_addr; m_buf = m_mem[m_addr]; m_addr = m_addr + 14'd1;
            end
         end
      end
      if (pf) begin
         check("pf_rd_strobe", {31'd0, vram_rd}, 32'd1);
         check("pf_rd_addr", {18'd0, vram_addr}, {18'd0, pfa});
      end
      idle_gap();
   endtask

   task automatic data_wr(input logic [7:0] b);
      logic [13:0] a;
      busy = 1'b1; a = m_addr;
      bus_op(1'b0, 1'b1, b);
      check("wr_strobe", {31'd0, vram_wr}, 32'd1);
      check("wr_addr", {18'd0, vram_addr}, {18'd0, a});
      check("wr_data", {24'd0, vram_dout}, {24'd0, b});
      m_mem[a] = b; m_buf = b; m_addr = a + 14'd1; m_flag = 1'b0;
      @(posedge clk); #1;
      check("wr_single", {31'd0, vram_wr}, 32'd0);
      idle_gap();
   endtask

   task automatic data_rd(output logic [7:0] val);
      logic [13:0] a;
      busy = 1'b1;
      bus_op(1'b0, 1'b0, 8'h00);
      val = cpu_dout;
      check("data_rd", {24'd0, cpu_dout}, {24'd0, m_buf});
      a = m_addr; m_buf = m_mem[a]; m_addr = a + 14'd1; m_flag = 1'b0;
      check("rd_pf_strobe", {31'd0, vram_rd}, 32'd1);
      check("rd_pf_addr", {18'd0, vram_addr}, {18'd0, a});
      idle_gap();
   endtask

   task automatic status_rd(input logic [7:0] exp, input string nm);
      busy = 1'b1;
      bus_op(1'b1, 1'b0, 8'h00);
      check(nm, {24'd0, cpu_dout}, {24'd0, exp});
      m_flag = 1'b0;
      @(posedge clk); #1;
      nint_after = n_int;
      idle_gap();
   endtask

   task automatic preload(input logic [13:0] a, input logic [7:0] d);
      @(negedge clk); pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1 pre_en = 1'b0;
      m_mem[a] = d;
   endtask

   task automatic do_reset();
      busy = 1'b1;
      n_reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) n_reset = 1'b1;
      idle_gap();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [7:0] tab [12];
   initial begin
      tab = '{8'h0F, 8'h82, 8'hFF, 8'h83, 8'h07, 8'h84, 8'h7F, 8'h85, 8'h03, 8'h86, 8'h02, 8'h80};
      n_reset = 1'b0; port_sel = 0; cpu_wr = 0; cpu_rd = 0; cpu_din = 0;
      vblank = 0; coll_in = 0; sprite5_in = 5'h0A;
      model_reset();
      repeat (3) @(posedge clk); #1;
      check("rst_dout",   {24'd0, cpu_dout}, 32'h0);
      check("rst_wr",     {31'd0, vram_wr}, 32'd0);
      check("rst_rd",     {31'd0, vram_rd}, 32'd0);
      check("rst_nint",   {31'd0, n_int}, 32'd1);
      check("rst_mode",   {30'd0, mode}, 32'd1);
      check("rst_vid_on", {31'd0, video_on}, 32'd0);
      check("rst_name",   {18'd0, name_table_addr}, 32'h0);
      @(negedge clk) n_reset = 1'b1;
      idle_gap();

      ctrl_wr(8'h05); ctrl_wr(8'h87);
      check("r7_text", {28'd0, text_color}, 32'h0);
      check("r7_back", {28'd0, back_color}, 32'h5);
      ctrl_wr(8'h10); ctrl_wr(8'h81);
      check("r1_text_mode", {30'd0, mode}, 32'd0);

      for (int i = 0; i < 12; i += 2) begin
         ctrl_wr(tab[i]); ctrl_wr(tab[i+1]);
      end
      check("name_lit",  {18'd0, name_table_addr}, 32'h3C00);
      check("color_lit", {18'd0, color_table_addr}, 32'h3FC0);
      check("font_lit",  {18'd0, font_addr}, 32'h3800);
      check("sattr_lit", {18'd0, sprite_attr_addr}, 32'h3F80);
      check("spat_lit",  {18'd0, sprite_pattern_table_addr}, 32'h1800);
      ctrl_wr(8'h00); ctrl_wr(8'h81);
      check("mode_g2", {30'd0, mode}, 32'd2);
      ctrl_wr(8'h00); ctrl_wr(8'h80); ctrl_wr(8'h08); ctrl_wr(8'h81);
      check("mode_mc", {30'd0, mode}, 32'd3);
      ctrl_wr(8'h43); ctrl_wr(8'h81);

      ctrl_wr(8'hFF); ctrl_wr(8'h7F);
      data_wr(8'hAA); data_wr(8'hBB); data_wr(8'hCC);
      check("vram_3fff", {24'd0, vmem[14'h3FFF]}, 32'hAA);
      check("vram_0000", {24'd0, vmem[14'h0000]}, 32'hBB);
      check("vram_0001", {24'd0, vmem[14'h0001]}, 32'hCC);

      preload(14'h0100, 8'h11); preload(14'h0101, 8'h22);
      ctrl_wr(8'h00); ctrl_wr(8'h01);
      data_rd(got); check("rd1_lit", {24'd0, got}, 32'h11);
      data_rd(got); check("rd2_lit", {24'd0, got}, 32'h22);

      ctrl_wr(8'h40); data_wr(8'h55);
      check("vram_0103", {24'd0, vmem[14'h0103]}, 32'h55);
      ctrl_wr(8'h09); ctrl_wr(8'h87);

      ctrl_wr(8'h20); ctrl_wr(8'h81);
      check("nint_idle", {31'd0, n_int}, 32'd1);
      cnt = 0;
      @(negedge clk) vblank = 1'b1;
      while (n_int !== 1'b0 && cnt < 10) begin
         @(posedge clk); #1; cnt++;
      end
      check("nint_low", {31'd0, n_int}, 32'd0);
      check("nint_latency_ok", {31'd0, cnt <= SYNC_STAGES + 2}, 32'd1);
      status_rd(8'h8A, "stat_f_set");
      check("nint_release", {31'd0, nint_after}, 32'd1);
      status_rd(8'h0A, "stat_f_clear");

      @(negedge clk) coll_in = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk) coll_in = 1'b0;
      repeat (4) @(posedge clk);
      status_rd(8'h2A, "stat_c_set");
      status_rd(8'h0A, "stat_c_clear");

      @(negedge clk) vblank = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) vblank = 1'b1;
      @(posedge clk); @(posedge clk);
      status_rd(8'h0A, "stat_coincident");
      check("nint_coincident", {31'd0, nint_after}, 32'd0);
      ctrl_wr(8'h00); ctrl_wr(8'h81);
      check("nint_masked", {31'd0, n_int}, 32'd1);
      ctrl_wr(8'h20); ctrl_wr(8'h81);
      check("nint_unmasked", {31'd0, n_int}, 32'd0);
      status_rd(8'h8A, "stat_f_kept");
      check("nint_after_kept", {31'd0, nint_after}, 32'd1);

      ctrl_wr(8'h00);
      busy = 1'b1;
      bus_op(1'b1, 1'b1, 8'h01);
      check("rd_inflight", {31'd0, vram_rd}, 32'd1);
      n_reset = 1'b0;
      #1 check("rd_async_drop", {31'd0, vram_rd}, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) n_reset = 1'b1;
      idle_gap();

      ctrl_wr(8'h04); ctrl_wr(8'h84);
      ctrl_wr(8'h34);
      do_reset();
      ctrl_wr(8'h02); ctrl_wr(8'h82);
      check("rst_name_0800", {18'd0, name_table_addr}, 32'h0800);
      check("rst_font_0",    {18'd0, font_addr}, 32'h0000);
      check("rst_mode_1",    {30'd0, mode}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
